// File: rtl/quad_step_decoder.sv
// Quadrature decoder: per-channel 2-flop synchronizer and glitch filter, then
// step/direction/illegal-transition decoding of the filtered {A,B} phase.
module quad_step_decoder #(
    parameter int FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       clear_err,
    output logic       step,
    output logic       dir,
    output logic       err,
    output logic [1:0] phase,
    output logic       ready
);

    localparam logic [3:0] FILT_MAX  = 4'(FILTER_LEN - 1);
    localparam logic [4:0] START_MAX = 5'(FILTER_LEN + 1);

    logic [1:0] s1_q;
    logic [1:0] s2_q;
    logic [1:0] f_q;
    logic [1:0] f_d;
    logic [3:0] cnt_q [2];
    logic [3:0] cnt_d [2];
    logic [1:0] prev_q;
    logic [4:0] start_q;
    logic [4:0] start_d;
    logic       ready_q;
    logic       ready_d;
    logic       settle_q;
    logic       step_q;
    logic       step_d;
    logic       dir_q;
    logic       dir_d;
    logic       err_q;
    logic       err_d;
    logic [1:0] diff_s;
    logic       decode_s;

    // Glitch filter: accept a new synchronized level after FILTER_LEN consecutive differing samples.
    always_comb begin
        f_d = f_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] != f_q[i]) begin
                if (cnt_q[i] == FILT_MAX) begin
                    f_d[i]   = s2_q[i];
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end else begin
                cnt_d[i] = 4'd0;
            end
        end
    end

    // Startup counter: ready rises FILTER_LEN+2 edges after reset release.
    always_comb begin
        if (start_q == START_MAX) begin
            start_d = start_q;
            ready_d = 1'b1;
        end else begin
            start_d = start_q + 5'd1;
            ready_d = ready_q;
        end
    end

    // Decoding waits one cycle beyond ready so prev has caught up with a phase
    // that settled on the same edge ready rose (inputs held high through reset).
    always_comb begin
        diff_s   = f_q ^ prev_q;
        decode_s = ready_q & settle_q & enable;
        step_d   = 1'b0;
        dir_d    = dir_q;
        case (diff_s)
            2'b01, 2'b10: begin
                if (decode_s) begin
                    step_d = 1'b1;
                    dir_d  = prev_q[1] ^ f_q[0];
                end else begin
                    step_d = 1'b0;
                end
            end
            default: begin
                step_d = 1'b0;
            end
        endcase
        if (decode_s && (diff_s == 2'b11)) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset discards any partially filtered level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 2'b00;
            s2_q     <= 2'b00;
            f_q      <= 2'b00;
            cnt_q[0] <= 4'd0;
            cnt_q[1] <= 4'd0;
            prev_q   <= 2'b00;
            start_q  <= 5'd0;
            ready_q  <= 1'b0;
            settle_q <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= {a_in, b_in};
            s2_q     <= s1_q;
            f_q      <= f_d;
            cnt_q    <= cnt_d;
            prev_q   <= f_q;
            start_q  <= start_d;
            ready_q  <= ready_d;
            settle_q <= ready_q;
            step_q   <= step_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

    assign step  = step_q;
    assign dir   = dir_q;
    assign err   = err_q;
    assign phase = f_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random stimulus, all
// checked cycle by cycle against a behavioural model of the decoder.
module tb_quad_step_decoder;

    localparam int FL = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       clear_err = 1'b0;
    logic       step;
    logic       dir;
    logic       err;
    logic [1:0] phase;
    logic       ready;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [19:0] ha, hb;
    logic        mfa, mfb;
    logic [1:0]  m_phase, m_prev;
    logic        m_step, m_dir, m_err, m_ready;
    int          n_edges;

    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    always #5 clk = ~clk;

    quad_step_decoder #(.FILTER_LEN(FL)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .a_in      (a_in),
        .b_in      (b_in),
        .clear_err (clear_err),
        .step      (step),
        .dir       (dir),
        .err       (err),
        .phase     (phase),
        .ready     (ready)
    );

    function automatic int pos(logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Filtered level flips only when the last FL synchronizer outputs all disagree with it.
    function automatic logic filt(logic [19:0] h, logic f);
        for (int k = 2; k < FL + 2; k++) begin
            if (h[k] == f) return f;
        end
        return ~f;
    endfunction

    function automatic logic [5:0] obs();
        return {step, dir, err, phase, ready};
    endfunction

    function automatic logic [5:0] expv();
        return {m_step, m_dir, m_err, m_phase, m_ready};
    endfunction

    task automatic drive(input logic [1:0] p);
        a_in = p[1];
        b_in = p[0];
    endtask

    // Advance one clock; the model sees the same pre-edge inputs as the DUT.
    task automatic tick();
        int d;
        logic live;
        @(posedge clk);
        if (reset) begin
            ha = '0; hb = '0; mfa = 1'b0; mfb = 1'b0;
            m_phase = 2'b00; m_prev = 2'b00;
            m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0; m_ready = 1'b0;
            n_edges = 0;
        end else begin
            n_edges++;
            ha = {ha[18:0], a_in};
            hb = {hb[18:0], b_in};
            d = (pos(m_phase) - pos(m_prev) + 4) % 4;
            // decoding is live from the edge after the first one that sees ready=1
            live = (n_edges >= FL + 4) && enable;
            m_step = live && (d == 1 || d == 3);
            if (m_step) m_dir = (d == 1);
            if (live && d == 2) m_err = 1'b1;
            else if (clear_err) m_err = 1'b0;
            m_ready = (n_edges >= FL + 2);
            m_prev  = m_phase;
            mfa = filt(ha, mfa);
            mfb = filt(hb, mfb);
            m_phase = {mfa, mfb};
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first_ready = -1;
        int nsteps = 0;
        tick(); tick();
        checks++;
        if (obs() !== 6'b000000) begin
            errors++;
            $display("FAIL reset_state got %b want 000000", obs());
        end
        enable = 1'b1;
        drive(2'b00);
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_model c=%0d got %b want %b", c, obs(), expv());
            end
            if (ready && first_ready < 0) first_ready = c;
            if (step) nsteps++;
        end
        checks++;
        if (first_ready != 5 || nsteps != 0 || err !== 1'b0 || phase !== 2'b00) begin
            errors++;
            $display("FAIL startup got ready_at=%0d steps=%0d err=%b phase=%b want 5 0 0 00",
                     first_ready, nsteps, err, phase);
        end
    endtask

    // Each change is sampled at the first edge (E0); its step appears 5 edges later.
    task automatic test_forward();
        for (int s = 1; s <= 4; s++) begin
            int first = -1;
            int nsteps = 0;
            drive(seq[s % 4]);
            for (int c = 1; c <= 8; c++) begin
                tick();
                checks++;
                if (obs() !== expv()) begin
                    errors++;
                    $display("FAIL fwd_model s=%0d c=%0d got %b want %b", s, c, obs(), expv());
                end
                if (step) begin
                    nsteps++;
                    if (first < 0) first = c;
                end
            end
            checks++;
            if (nsteps != 1 || first != 6 || dir !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL fwd_step s=%0d got steps=%0d at=%0d dir=%b err=%b want 1 6 1 0",
                         s, nsteps, first, dir, err);
            end
        end
    endtask

    task automatic test_reverse();
        for (int s = 0; s < 4; s++) begin
            int nsteps = 0;
            logic want_dir;
            // 10, 11, 01 going down, then 11 going up again
            drive(s < 3 ? seq[3 - s] : seq[2]);
            want_dir = (s == 3);
            for (int c = 1; c <= 8; c++) begin
                tick();
                checks++;
                if (obs() !== expv()) begin
                    errors++;
                    $display("FAIL rev_model s=%0d c=%0d got %b want %b", s, c, obs(), expv());
                end
                if (step) nsteps++;
            end
            checks++;
            if (nsteps != 1 || dir !== want_dir) begin
                errors++;
                $display("FAIL rev_step s=%0d got steps=%0d dir=%b want 1 %b", s, nsteps, dir, want_dir);
            end
        end
    endtask

    task automatic test_glitch();
        int nsteps = 0;
        for (int s = 0; s < 2; s++) begin
            drive(s == 0 ? 2'b10 : 2'b00);
            for (int c = 1; c <= 8; c++) begin
                tick();
                checks++;
                if (obs() !== expv()) begin
                    errors++;
                    $display("FAIL glitch_setup c=%0d got %b want %b", c, obs(), expv());
                end
            end
        end
        for (int c = 1; c <= 8; c++) begin
            a_in = (c <= 2);
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL glitch_short c=%0d got %b want %b", c, obs(), expv());
            end
            if (step) nsteps++;
        end
        checks++;
        if (nsteps != 0 || phase !== 2'b00) begin
            errors++;
            $display("FAIL glitch_reject got steps=%0d phase=%b want 0 00", nsteps, phase);
        end
        nsteps = 0;
        for (int c = 1; c <= 6; c++) begin
            a_in = (c <= 3);
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL glitch_long c=%0d got %b want %b", c, obs(), expv());
            end
            if (step) nsteps++;
        end
        checks++;
        if (nsteps != 1 || phase !== 2'b10 || dir !== 1'b0) begin
            errors++;
            $display("FAIL glitch_accept got steps=%0d phase=%b dir=%b want 1 10 0", nsteps, phase, dir);
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL glitch_return c=%0d got %b want %b", c, obs(), expv());
            end
        end
    endtask

    task automatic test_illegal();
        int nsteps = 0;
        drive(2'b11);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL ill_model c=%0d got %b want %b", c, obs(), expv());
            end
            if (step) nsteps++;
        end
        checks++;
        if (nsteps != 0 || err !== 1'b1 || phase !== 2'b11) begin
            errors++;
            $display("FAIL ill_jump got steps=%0d err=%b phase=%b want 0 1 11", nsteps, err, phase);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL ill_clear got err=%b want 0", err);
        end
        drive(2'b00);
        for (int c = 1; c <= 8; c++) begin
            clear_err = (c == 6);
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL ill_setwins_model c=%0d got %b want %b", c, obs(), expv());
            end
            if (c == 6) begin
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL ill_setwins got err=%b want 1", err);
                end
            end
        end
        clear_err = 1'b0;
    endtask

    task automatic test_enable();
        int nsteps = 0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        enable = 1'b0;
        drive(2'b01);
        for (int c = 1; c <= 12; c++) begin
            if (c == 9) enable = 1'b1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL en_model c=%0d got %b want %b", c, obs(), expv());
            end
            if (step) nsteps++;
        end
        checks++;
        if (nsteps != 0 || err !== 1'b0 || phase !== 2'b01) begin
            errors++;
            $display("FAIL en_off got steps=%0d err=%b phase=%b want 0 0 01", nsteps, err, phase);
        end
        drive(2'b11);
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL en_on_model c=%0d got %b want %b", c, obs(), expv());
            end
            if (step) nsteps++;
        end
        checks++;
        if (nsteps != 1 || dir !== 1'b1) begin
            errors++;
            $display("FAIL en_on got steps=%0d dir=%b want 1 1", nsteps, dir);
        end
    endtask

    task automatic test_reset_mid();
        int first_ready = -1;
        int nsteps = 0;
        logic [1:0] ph_at_ready = 2'b00;
        drive(2'b10);
        for (int c = 1; c <= 3; c++) tick();
        reset = 1'b1;
        drive(2'b11);
        tick(); tick();
        checks++;
        if (obs() !== 6'b000000) begin
            errors++;
            $display("FAIL midreset_state got %b want 000000", obs());
        end
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL midreset_model c=%0d got %b want %b", c, obs(), expv());
            end
            if (ready && first_ready < 0) begin
                first_ready = c;
                ph_at_ready = phase;
            end
            if (step) nsteps++;
        end
        checks++;
        if (first_ready != 5 || ph_at_ready !== 2'b11 || nsteps != 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_settle got ready_at=%0d phase=%b steps=%0d err=%b want 5 11 0 0",
                     first_ready, ph_at_ready, nsteps, err);
        end
    endtask

    task automatic test_random();
        int cur = pos({a_in, b_in});
        for (int seg = 0; seg < 250; seg++) begin
            int k = int'($urandom_range(0, 9));
            int hold = int'($urandom_range(1, 10));
            int glen = 0;
            if (k < 6) cur = (cur + (($urandom_range(0, 1) == 0) ? 1 : 3)) % 4;
            else if (k < 8) cur = (cur + 2) % 4;
            else glen = int'($urandom_range(1, FL));
            drive(seq[cur]);
            if (glen > 0) a_in = ~a_in;
            for (int c = 1; c <= hold + glen; c++) begin
                if (c == glen + 1) drive(seq[cur]);
                enable = ($urandom_range(0, 9) != 0);
                clear_err = ($urandom_range(0, 15) == 0);
                tick();
                checks++;
                if (obs() !== expv()) begin
                    errors++;
                    $display("FAIL rand_model seg=%0d c=%0d got %b want %b", seg, c, obs(), expv());
                end
            end
        end
        enable = 1'b1;
        clear_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
